// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, Rcon, round counts, FSM encoding
// and the word-level helpers used by the key schedule.
package aes_pkg;

    localparam int NR_128 = 10;
    localparam int NR_256 = 14;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // GF(2^8) inverse as a^254 (0 maps to 0), then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
                 ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        unique case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]),
                sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Four new schedule words from the four words Nk positions back.
    function automatic logic [127:0] key_step(
        input logic [127:0] prev,
        input logic [31:0]  t
    );
        logic [31:0] n0, n1, n2, n3;
        n0 = prev[127:96] ^ t;
        n1 = prev[95:64] ^ n0;
        n2 = prev[63:32] ^ n1;
        n3 = prev[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

endpackage

// File: rtl/aes_round_fn.sv
// One combinational AES encryption round; the last round skips
// MixColumns.
module aes_round_fn
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] nxt
);

    logic [127:0] sb;
    logic [127:0] sr;
    logic [127:0] mc;

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    always_comb begin
        sb = '0;
        for (int i = 0; i < 16; i++)
            sb[127-8*i -: 8] = sbox(state[127-8*i -: 8]);
    end

    // Byte 4*c+r sits at row r, column c; row r rotates left by r.
    always_comb begin
        sr = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[127-8*(4*c+r) -: 8] =
                    sb[127-8*(4*((c+r)%4)+r) -: 8];
    end

    always_comb begin
        mc = '0;
        for (int c = 0; c < 4; c++)
            mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    end

    assign nxt = (last ? sr : mc) ^ rk;

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES encryption core, one round per clock, with an
// on-the-fly key schedule and optional CBC chaining.
module aes_iter_core
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128,
    parameter int CBC_EN   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_BITS-1:0] key,
    input  logic [127:0]        blk,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        iv,
    input  logic                iv_load,
    output logic [127:0]        ct,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam logic [3:0] NR =
        (KEY_BITS == 256) ? 4'(NR_256) : 4'(NR_128);

    fsm_t                fsm;
    fsm_t                fsm_nxt;
    logic [3:0]          rnd;
    logic                last;
    logic [127:0]        st;
    logic [127:0]        chain;
    logic [127:0]        chain_in;
    logic [127:0]        rk;
    logic [127:0]        rnd_out;
    logic [KEY_BITS-1:0] kreg;
    logic [KEY_BITS-1:0] k_nxt;

    assign last     = (rnd == NR);
    assign ct       = st;
    assign chain_in = (CBC_EN != 0) ? (iv_load ? iv : chain) : '0;

    always_ff @(posedge clk) begin
        if (rst) fsm <= IDLE;
        else     fsm <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt   = fsm;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (fsm)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) fsm_nxt = RUN;
            end
            RUN: begin
                if (last) fsm_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) fsm_nxt = IDLE;
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= '0;
            kreg  <= '0;
            chain <= '0;
            rnd   <= '0;
        end else begin
            unique case (fsm)
                IDLE: begin
                    if (CBC_EN != 0 && iv_load) chain <= iv;
                    if (in_valid) begin
                        st   <= blk ^ chain_in ^ key[KEY_BITS-1 -: 128];
                        kreg <= key;
                        rnd  <= 4'd1;
                    end
                end
                RUN: begin
                    st   <= rnd_out;
                    kreg <= k_nxt;
                    rnd  <= last ? 4'd0 : rnd + 4'd1;
                end
                DONE: begin
                    if (CBC_EN != 0 && out_ready) chain <= st;
                end
                default: ;
            endcase
        end
    end

    if (KEY_BITS == 128) begin : g_k128
        assign rk    = key_step(kreg,
                           sub_word(rot_word(kreg[31:0]))
                           ^ {rcon(rnd), 24'h0});
        assign k_nxt = rk;
    end else if (KEY_BITS == 256) begin : g_k256
        // kreg keeps the two most recent round keys {older, newer}.
        logic [127:0] older;
        logic [127:0] newer;
        logic [127:0] fresh;
        logic [31:0]  t;
        assign older = kreg[255:128];
        assign newer = kreg[127:0];
        assign t     = rnd[0]
                     ? sub_word(newer[31:0])
                     : sub_word(rot_word(newer[31:0]))
                       ^ {rcon({1'b0, rnd[3:1]}), 24'h0};
        assign fresh = key_step(older, t);
        assign rk    = (rnd == 4'd1) ? newer : fresh;
        assign k_nxt = (rnd == 4'd1) ? kreg : {newer, fresh};
    end else begin : g_bad
        $error("aes_iter_core: KEY_BITS must be 128 or 256");
    end

    aes_round_fn u_round (
        .state (st),
        .rk    (rk),
        .last  (last),
        .nxt   (rnd_out)
    );

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed bench for aes_iter_core: FIPS/SP800-38A vectors on
// AES-128, AES-256 and an AES-128 CBC instance.
module tb_aes_iter_core;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] key256;
    logic [127:0] key128;
    logic [127:0] blk;
    logic [127:0] iv;
    logic         iv_load;
    logic         out_ready;
    logic [2:0]   vin;
    logic         ir0, ir1, ir2;
    logic         ov0, ov1, ov2;
    logic [127:0] ct0, ct1, ct2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_iter_core #(.KEY_BITS(128), .CBC_EN(0)) u_ecb128 (
        .clk(clk), .rst(rst), .key(key128), .blk(blk),
        .in_valid(vin[0]), .in_ready(ir0), .iv(iv),
        .iv_load(iv_load), .ct(ct0), .out_valid(ov0),
        .out_ready(out_ready)
    );

    aes_iter_core #(.KEY_BITS(256), .CBC_EN(0)) u_ecb256 (
        .clk(clk), .rst(rst), .key(key256), .blk(blk),
        .in_valid(vin[1]), .in_ready(ir1), .iv(iv),
        .iv_load(iv_load), .ct(ct1), .out_valid(ov1),
        .out_ready(out_ready)
    );

    aes_iter_core #(.KEY_BITS(128), .CBC_EN(1)) u_cbc128 (
        .clk(clk), .rst(rst), .key(key128), .blk(blk),
        .in_valid(vin[2]), .in_ready(ir2), .iv(iv),
        .iv_load(iv_load), .ct(ct2), .out_valid(ov2),
        .out_ready(out_ready)
    );

    typedef struct {
        int           dut;
        logic [255:0] key;
        logic [127:0] blk;
        logic [127:0] ct;
        int           lat;
    } vec_t;

    vec_t vecs[5];

    function automatic logic get_ir(input int s);
        return (s == 0) ? ir0 : (s == 1) ? ir1 : ir2;
    endfunction

    function automatic logic get_ov(input int s);
        return (s == 0) ? ov0 : (s == 1) ? ov1 : ov2;
    endfunction

    function automatic logic [127:0] get_ct(input int s);
        return (s == 0) ? ct0 : (s == 1) ? ct1 : ct2;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic send(input int s, input logic [255:0] k,
                        input logic [127:0] b, input logic ld,
                        input logic [127:0] ivv);
        int n;
        n = 0;
        key256  = k;
        key128  = k[127:0];
        blk     = b;
        iv      = ivv;
        iv_load = ld;
        while (!get_ir(s) && n < 40) begin
            step();
            n++;
        end
        check("in_ready_before_send", {127'b0, get_ir(s)}, 128'h1);
        vin    = '0;
        vin[s] = 1'b1;
        step();
        vin     = '0;
        iv_load = 1'b0;
        key256  = ~k;
        key128  = ~k[127:0];
        blk     = ~b;
        iv      = ~ivv;
    endtask

    task automatic wait_out(input int s, input logic noisy,
                            output int lat, output logic ir_seen);
        lat     = 0;
        ir_seen = 1'b0;
        vin[s]  = noisy;
        while (!get_ov(s) && lat < 40) begin
            if (get_ir(s)) ir_seen = 1'b1;
            step();
            lat++;
        end
        vin = '0;
        if (!get_ov(s)) begin
            checks++;
            errors++;
            $display("FAIL out_valid_timeout: dut %0d got 0 expected 1",
                     s);
        end
    endtask

    task automatic take(input int s);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("ov_after_handshake", {127'b0, get_ov(s)}, 128'h0);
        check("ir_after_handshake", {127'b0, get_ir(s)}, 128'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic irs;
        logic bad;
        logic [127:0] cbc_key;

        vecs[0] = '{0, 256'h000102030405060708090a0b0c0d0e0f,
                    128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 10};
        vecs[1] = '{1,
            256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    128'h00112233445566778899aabbccddeeff,
                    128'h8ea2b7ca516745bfeafc49904b496089, 14};
        vecs[2] = '{0, 256'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32, 10};
        vecs[3] = '{0, 256'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h6bc1bee22e409f96e93d7e117393172a,
                    128'h3ad77bb40d7a3660a89ecaf32466ef97, 10};
        vecs[4] = '{1,
            256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                    128'h6bc1bee22e409f96e93d7e117393172a,
                    128'hf3eed1bdb5d2a03c064b5a7e3db181f8, 14};

        rst       = 1'b1;
        vin       = '0;
        key256    = '0;
        key128    = '0;
        blk       = '0;
        iv        = '0;
        iv_load   = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        for (int s = 0; s < 3; s++) begin
            check("reset_out_valid", {127'b0, get_ov(s)}, 128'h0);
            check("reset_in_ready", {127'b0, get_ir(s)}, 128'h1);
            check("reset_ct", get_ct(s), 128'h0);
        end

        // ECB instances must ignore iv_load; odd rows also hold
        // in_valid high while busy.
        for (int i = 0; i < 5; i++) begin
            send(vecs[i].dut, vecs[i].key, vecs[i].blk, 1'(i % 2),
                 128'hdeadbeef_01234567_89abcdef_cafef00d);
            wait_out(vecs[i].dut, 1'(i % 2), lat, irs);
            check("vec_ct", get_ct(vecs[i].dut), vecs[i].ct);
            check("vec_latency", 128'(lat), 128'(vecs[i].lat));
            check("vec_busy_in_ready", {127'b0, irs}, 128'h0);
            take(vecs[i].dut);
        end

        send(0, vecs[0].key, vecs[0].blk, 1'b0, '0);
        wait_out(0, 1'b0, lat, irs);
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (ct0 !== vecs[0].ct || !ov0 || ir0) bad = 1'b1;
        end
        check("bp_hold", {127'b0, bad}, 128'h0);
        check("bp_ct", ct0, vecs[0].ct);
        take(0);

        send(0, vecs[2].key, vecs[2].blk, 1'b0, '0);
        for (int c = 0; c < 4; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_out_valid", {127'b0, ov0}, 128'h0);
        check("rst_in_ready", {127'b0, ir0}, 128'h1);
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (ov0 || ov1 || ov2) bad = 1'b1;
            step();
        end
        check("rst_no_out_valid", {127'b0, bad}, 128'h0);
        send(0, vecs[2].key, vecs[2].blk, 1'b0, '0);
        wait_out(0, 1'b0, lat, irs);
        check("post_rst_ct", ct0, vecs[2].ct);
        check("post_rst_latency", 128'(lat), 128'd10);
        take(0);

        cbc_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        send(2, {128'h0, cbc_key},
             128'h6bc1bee22e409f96e93d7e117393172a, 1'b1,
             128'h000102030405060708090a0b0c0d0e0f);
        wait_out(2, 1'b0, lat, irs);
        check("cbc_ct1", ct2, 128'h7649abac8119b246cee98e9b12e9197d);
        check("cbc_latency", 128'(lat), 128'd10);
        take(2);

        send(2, {128'h0, cbc_key},
             128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b0, '0);
        step();
        step();
        iv      = 128'hffeeddccbbaa99887766554433221100;
        iv_load = 1'b1;
        step();
        iv_load = 1'b0;
        wait_out(2, 1'b0, lat, irs);
        check("cbc_ct2", ct2, 128'h5086cb9b507219ee95db113a917678b2);
        take(2);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
